io_input_conditioner: RTL

Conditions the raw board inputs (10 slide switches, 4 push keys) into the 14-bit `io_input_bus` that the data memory's IO read block samples. Each input bit is synchronised by two flops, then debounced by a per-bit stability counter. Key bits are normalised to active-high "pressed", with optional sticky press latching so software polling cannot miss a short press. Sits between the FPGA pins and the data memory; it is the only producer of `io_input_bus`.

---
 rtl/io_input_conditioner_pkg.sv | 19 +
 rtl/io_input_conditioner_debounce_bit.sv | 55 +++++
 rtl/io_input_conditioner.sv | 74 +++++++
 3 files changed

// File: rtl/io_input_conditioner_pkg.sv
// Board input map shared by the input conditioner and the IO read decode.
// Bus layout: switches in the low bits, keys above them.
package io_input_conditioner_pkg;

   localparam int IO_SW_WIDTH  = 10;
   localparam int IO_KEY_WIDTH = 4;
   localparam int IO_SW_LSB    = 0;
   localparam int IO_KEY_LSB   = 10;
   localparam int IO_BUS_WIDTH = IO_SW_WIDTH + IO_KEY_WIDTH;

   // Map a debounced key level onto "pressed = 1".
   function automatic logic [IO_KEY_WIDTH-1:0] key_norm(
      input logic [IO_KEY_WIDTH-1:0] lvl,
      input bit                      active_low
   );
      return active_low ? ~lvl : lvl;
   endfunction

endpackage

// File: rtl/io_input_conditioner_debounce_bit.sv
// One input bit: two-flop synchroniser, stable level and stability counter.
// level_nxt exposes the level being loaded this cycle for edge detection.
module debounce_bit #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_WIDTH       = 16,
   parameter bit RESET_LEVEL     = 1'b0
) (
   input  logic clock,
   input  logic reset,
   input  logic raw,
   output logic level,
   output logic level_nxt
);

   localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   logic                 sync1_q, sync1_d;
   logic                 sync2_q, sync2_d;
   logic                 state_q, state_d;
   logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

   // Synchronise, then accept a new level only after it has held LAST+1 cycles.
   always_comb begin
      sync1_d = raw;
      sync2_d = sync1_q;
      state_d = state_q;
      cnt_d   = '0;
      if (sync2_q != state_q) begin
         if (cnt_q == LAST) begin
            state_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
         end
      end
   end

   // State registers; key bits reset to the released level.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1_q <= RESET_LEVEL;
         sync2_q <= RESET_LEVEL;
         state_q <= RESET_LEVEL;
         cnt_q   <= '0;
      end else begin
         sync1_q <= sync1_d;
         sync2_q <= sync2_d;
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   assign level     = state_q;
   assign level_nxt = state_d;

endmodule

// File: rtl/io_input_conditioner.sv
// Debounces switches and keys onto io_input_bus, with key press events
// and optional sticky press flags cleared by software.
module io_input_conditioner
   import io_input_conditioner_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int CNT_WIDTH       = 16,
   parameter bit KEY_ACTIVE_LOW  = 1'b1,
   parameter bit KEY_STICKY      = 1'b0
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [IO_SW_WIDTH-1:0]  sw_raw,
   input  logic [IO_KEY_WIDTH-1:0] key_raw,
   input  logic [IO_KEY_WIDTH-1:0] key_clear,
   output logic [IO_BUS_WIDTH-1:0] io_input_bus,
   output logic [IO_KEY_WIDTH-1:0] key_event
);

   logic [IO_BUS_WIDTH-1:0] raw_all;
   logic [IO_BUS_WIDTH-1:0] lvl;
   logic [IO_BUS_WIDTH-1:0] lvl_nxt;

   logic [IO_KEY_WIDTH-1:0] pressed;
   logic [IO_KEY_WIDTH-1:0] pressed_nxt;
   logic [IO_KEY_WIDTH-1:0] event_q, event_d;
   logic [IO_KEY_WIDTH-1:0] flag_q, flag_d;

   assign raw_all[IO_SW_LSB +: IO_SW_WIDTH]   = sw_raw;
   assign raw_all[IO_KEY_LSB +: IO_KEY_WIDTH] = key_raw;

   for (genvar g = 0; g < IO_BUS_WIDTH; g++) begin : g_bit
      localparam bit RST_LVL = (g >= IO_KEY_LSB) ? KEY_ACTIVE_LOW : 1'b0;
      debounce_bit #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
         .CNT_WIDTH      (CNT_WIDTH),
         .RESET_LEVEL    (RST_LVL)
      ) u_db (
         .clock    (clock),
         .reset    (reset),
         .raw      (raw_all[g]),
         .level    (lvl[g]),
         .level_nxt(lvl_nxt[g])
      );
   end

   assign pressed     = key_norm(lvl[IO_KEY_LSB +: IO_KEY_WIDTH], KEY_ACTIVE_LOW);
   assign pressed_nxt = key_norm(lvl_nxt[IO_KEY_LSB +: IO_KEY_WIDTH], KEY_ACTIVE_LOW);

   // Event fires with the pressed edge; a set beats a same-cycle clear.
   always_comb begin
      event_d = pressed_nxt & ~pressed;
      flag_d  = '0;
      if (KEY_STICKY) begin
         flag_d = event_q | (flag_q & ~key_clear);
      end
   end

   // Event and sticky flag registers.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         event_q <= '0;
         flag_q  <= '0;
      end else begin
         event_q <= event_d;
         flag_q  <= flag_d;
      end
   end

   assign io_input_bus[IO_SW_LSB +: IO_SW_WIDTH]   = lvl[IO_SW_LSB +: IO_SW_WIDTH];
   assign io_input_bus[IO_KEY_LSB +: IO_KEY_WIDTH] = KEY_STICKY ? flag_q : pressed;
   assign key_event = event_q;

endmodule
